// File: rtl/ml_accel_pkg.sv
// Shared definitions for the systolic-array tile controller.
// Holds the register word indices, CTRL/STATUS bit positions, the sequencer
// state encoding, the AXI response codes and a byte-lane merge helper.
package ml_accel_pkg;

  // Register word indices (byte address bits [5:2])
  localparam logic [3:0] REG_CTRL    = 4'd0;
  localparam logic [3:0] REG_STATUS  = 4'd1;
  localparam logic [3:0] REG_M       = 4'd2;
  localparam logic [3:0] REG_K       = 4'd3;
  localparam logic [3:0] REG_N       = 4'd4;
  localparam logic [3:0] REG_TILES   = 4'd5;
  localparam logic [3:0] REG_VERSION = 4'd6;

  // CTRL bits
  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  // STATUS bits
  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ERR     = 2;
  localparam int ST_ABORTED = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_NEXT,
    S_DONE
  } seq_state_e;

  function automatic logic is_valid_idx(input logic [3:0] idx);
    return idx <= REG_VERSION;
  endfunction

  // Byte lanes with a clear strobe keep their old contents.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/ml_accel_tile_seq.sv
// Tile sequencer: walks the output tile grid of an M x K x N matmul and
// drives the per-tile LOAD / COMPUTE / DRAIN phases plus zero-padding masks.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, abort               single-cycle requests from the register file
//   m, k, n                    problem sizes
//   busy                       a run is in progress
//   done_set/err_set/aborted_set  one-cycle status set pulses
//   tiles_done                 completed tile count for the current run
//   array_en, load_weight      array phase controls (registered)
//   tile_row, tile_col         current output tile
//   row_mask, col_mask         valid rows/columns of the current tile
module ml_accel_tile_seq
  import ml_accel_pkg::*;
#(
  parameter int ARRAY_DIM = 16,
  parameter int SIZE_W    = 16,
  parameter int DRAIN_CYC = 2*ARRAY_DIM-1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [SIZE_W-1:0]    m,
  input  logic [SIZE_W-1:0]    k,
  input  logic [SIZE_W-1:0]    n,
  output logic                 busy,
  output logic                 done_set,
  output logic                 err_set,
  output logic                 aborted_set,
  output logic [31:0]          tiles_done,
  output logic                 array_en,
  output logic                 load_weight,
  output logic [SIZE_W-1:0]    tile_row,
  output logic [SIZE_W-1:0]    tile_col,
  output logic [ARRAY_DIM-1:0] row_mask,
  output logic [ARRAY_DIM-1:0] col_mask
);

  localparam int LOG2_DIM = $clog2(ARRAY_DIM);
  // Wide enough for ARRAY_DIM, 2^SIZE_W-1 and DRAIN_CYC (<= 127).
  localparam int CNT_W    = (SIZE_W > 8) ? SIZE_W : 8;
  localparam int BASE_W   = SIZE_W + LOG2_DIM + 1;

  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [SIZE_W-1:0] S_ONE      = SIZE_W'(1);
  localparam logic [CNT_W-1:0]  LOAD_LAST  = CNT_W'(ARRAY_DIM-1);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_CYC-1);
  localparam logic [SIZE_W:0]   ROUND_ADD  = (SIZE_W+1)'(ARRAY_DIM-1);

  seq_state_e        state;
  logic [CNT_W-1:0]  phase_cnt;
  logic [SIZE_W-1:0] tiles_m, tiles_n;
  logic [CNT_W-1:0]  compute_last;
  logic [SIZE_W:0]   m_round, n_round;
  logic              sizes_zero, last_col, last_tile, go;

  assign busy         = (state != S_IDLE);
  assign sizes_zero   = (m == '0) || (k == '0) || (n == '0);
  assign go           = start && !abort && (state == S_IDLE);
  assign err_set      = go && sizes_zero;
  assign done_set     = (state == S_DONE) && !abort;
  assign aborted_set  = abort && busy;
  assign compute_last = CNT_W'(k) - CNT_ONE;
  // Ceiling division by a power of two; one extra bit absorbs the carry.
  assign m_round      = {1'b0, m} + ROUND_ADD;
  assign n_round      = {1'b0, n} + ROUND_ADD;
  assign last_col     = (tile_col == tiles_n - S_ONE);
  assign last_tile    = last_col && (tile_row == tiles_m - S_ONE);

  // NOTE: sequential state uses <= so every flop samples pre-edge values,
  // independent of statement order inside the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      phase_cnt   <= '0;
      tiles_m     <= '0;
      tiles_n     <= '0;
      tile_row    <= '0;
      tile_col    <= '0;
      tiles_done  <= '0;
      array_en    <= 1'b0;
      load_weight <= 1'b0;
    end else if (aborted_set) begin
      state       <= S_IDLE;
      phase_cnt   <= '0;
      array_en    <= 1'b0;
      load_weight <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go && !sizes_zero) begin
            tiles_m     <= SIZE_W'(m_round >> LOG2_DIM);
            tiles_n     <= SIZE_W'(n_round >> LOG2_DIM);
            tile_row    <= '0;
            tile_col    <= '0;
            tiles_done  <= '0;
            phase_cnt   <= '0;
            array_en    <= 1'b1;
            load_weight <= 1'b1;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (phase_cnt == LOAD_LAST) begin
            phase_cnt   <= '0;
            load_weight <= 1'b0;
            state       <= S_COMPUTE;
          end else begin
            phase_cnt <= phase_cnt + CNT_ONE;
          end
        end
        S_COMPUTE: begin
          if (phase_cnt == compute_last) begin
            phase_cnt <= '0;
            state     <= S_DRAIN;
          end else begin
            phase_cnt <= phase_cnt + CNT_ONE;
          end
        end
        S_DRAIN: begin
          if (phase_cnt == DRAIN_LAST) begin
            phase_cnt <= '0;
            array_en  <= 1'b0;
            state     <= S_NEXT;
          end else begin
            phase_cnt <= phase_cnt + CNT_ONE;
          end
        end
        S_NEXT: begin
          tiles_done <= tiles_done + 32'd1;
          if (last_col) begin
            tile_col <= '0;
            tile_row <= tile_row + S_ONE;
          end else begin
            tile_col <= tile_col + S_ONE;
          end
          if (last_tile) begin
            state <= S_DONE;
          end else begin
            array_en    <= 1'b1;
            load_weight <= 1'b1;
            state       <= S_LOAD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Padding masks: element i of the tile is real data iff its global index
  // is below the matrix dimension.
  logic [BASE_W-1:0] row_base, col_base;
  assign row_base = BASE_W'({tile_row, {LOG2_DIM{1'b0}}});
  assign col_base = BASE_W'({tile_col, {LOG2_DIM{1'b0}}});

  // NOTE: outputs get a default before the loop so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    row_mask = '0;
    col_mask = '0;
    for (int i = 0; i < ARRAY_DIM; i++) begin
      row_mask[i] = (row_base + BASE_W'(i)) < BASE_W'(m);
      col_mask[i] = (col_base + BASE_W'(i)) < BASE_W'(n);
    end
  end

endmodule

// File: rtl/ml_accel_tile_ctrl_axil.sv
// AXI4-Lite control block for the systolic-array accelerator: config/status
// register file, W1C interrupt status and the tile sequencer instance.
// Ports:
//   s_axi_aclk, s_axi_aresetn   clock, async active-low reset
//   s_axi_aw*/w*/b*             AXI4-Lite write address/data/response
//   s_axi_ar*/r*                AXI4-Lite read address/data
//   array_en, load_weight       array phase controls
//   tile_row, tile_col          current output tile
//   row_mask, col_mask          zero-padding masks for the current tile
//   irq                         level interrupt
module ml_accel_tile_ctrl_axil
  import ml_accel_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 6,
  parameter int          ARRAY_DIM          = 16,
  parameter int          SIZE_W             = 16,
  parameter int          DRAIN_CYC          = 2*ARRAY_DIM-1,
  parameter logic [31:0] VERSION            = 32'h0002_0000
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic                            array_en,
  output logic                            load_weight,
  output logic [SIZE_W-1:0]               tile_row,
  output logic [SIZE_W-1:0]               tile_col,
  output logic [ARRAY_DIM-1:0]            row_mask,
  output logic [ARRAY_DIM-1:0]            col_mask,
  output logic                            irq
);

  logic [3:0]        wr_idx, rd_idx;
  logic              wr_en, wr_ctrl, wr_status, start_req, abort_req;
  logic              clr_done, clr_err, clr_aborted;
  logic              irq_en, done_r, err_r, aborted_r;
  logic              irq_en_nxt, done_nxt, err_nxt, aborted_nxt;
  logic [SIZE_W-1:0] m_r, k_r, n_r, m_nxt, k_nxt, n_nxt;
  logic              busy, done_set, err_set, aborted_set;
  logic [31:0]       tiles_done, rd_data;
  logic [1:0]        rd_resp;
  logic              unused_addr_bits;

  assign wr_idx = s_axi_awaddr[5:2];
  assign rd_idx = s_axi_araddr[5:2];
  assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // awready and wready rise together, so the ready cycle is the commit cycle.
  assign wr_en       = s_axi_awready;
  assign wr_ctrl     = wr_en && (wr_idx == REG_CTRL) && s_axi_wstrb[0];
  assign wr_status   = wr_en && (wr_idx == REG_STATUS) && s_axi_wstrb[0];
  assign start_req   = wr_ctrl && s_axi_wdata[CTRL_START];
  assign abort_req   = wr_ctrl && s_axi_wdata[CTRL_ABORT];
  assign clr_done    = wr_status && s_axi_wdata[ST_DONE];
  assign clr_err     = wr_status && s_axi_wdata[ST_ERR];
  assign clr_aborted = wr_status && s_axi_wdata[ST_ABORTED];

  always_comb begin
    irq_en_nxt  = irq_en;
    m_nxt       = m_r;
    k_nxt       = k_r;
    n_nxt       = n_r;
    if (wr_ctrl) irq_en_nxt = s_axi_wdata[CTRL_IRQ_EN];
    // A hardware set in the same cycle as a W1C clear wins.
    done_nxt    = done_set    || (done_r    && !clr_done);
    err_nxt     = err_set     || (err_r     && !clr_err);
    aborted_nxt = aborted_set || (aborted_r && !clr_aborted);
    // Sizes are frozen while a run is in flight.
    if (wr_en && !busy) begin
      case (wr_idx)
        REG_M:   m_nxt = SIZE_W'(apply_wstrb(32'(m_r), s_axi_wdata, s_axi_wstrb));
        REG_K:   k_nxt = SIZE_W'(apply_wstrb(32'(k_r), s_axi_wdata, s_axi_wstrb));
        REG_N:   n_nxt = SIZE_W'(apply_wstrb(32'(n_r), s_axi_wdata, s_axi_wstrb));
        default: ;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      irq_en    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      aborted_r <= 1'b0;
      m_r       <= SIZE_W'(ARRAY_DIM);
      k_r       <= SIZE_W'(ARRAY_DIM);
      n_r       <= SIZE_W'(ARRAY_DIM);
      irq       <= 1'b0;
    end else begin
      irq_en    <= irq_en_nxt;
      done_r    <= done_nxt;
      err_r     <= err_nxt;
      aborted_r <= aborted_nxt;
      m_r       <= m_nxt;
      k_r       <= k_nxt;
      n_r       <= n_nxt;
      irq       <= irq_en_nxt && (done_nxt || err_nxt || aborted_nxt);
    end
  end

  // Write channel: one transaction in flight; no accept while B is pending.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
    end else begin
      s_axi_awready <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
      s_axi_wready  <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
      if (wr_en) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= is_valid_idx(wr_idx) ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rd_idx)
      REG_CTRL:    rd_data[CTRL_IRQ_EN] = irq_en;
      REG_STATUS:  rd_data[3:0] = {aborted_r, err_r, done_r, busy};
      REG_M:       rd_data[SIZE_W-1:0] = m_r;
      REG_K:       rd_data[SIZE_W-1:0] = k_r;
      REG_N:       rd_data[SIZE_W-1:0] = n_r;
      REG_TILES:   rd_data = tiles_done;
      REG_VERSION: rd_data = VERSION;
      default:     rd_resp = RESP_SLVERR;
    endcase
  end

  // Read channel: data captured in the arready cycle and held until rready.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      s_axi_arready <= s_axi_arvalid && !s_axi_rvalid && !s_axi_arready;
      if (s_axi_arready) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_data;
        s_axi_rresp  <= rd_resp;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  ml_accel_tile_seq #(
    .ARRAY_DIM (ARRAY_DIM),
    .SIZE_W    (SIZE_W),
    .DRAIN_CYC (DRAIN_CYC)
  ) u_seq (
    .clk         (s_axi_aclk),
    .rst_n       (s_axi_aresetn),
    .start       (start_req),
    .abort       (abort_req),
    .m           (m_r),
    .k           (k_r),
    .n           (n_r),
    .busy        (busy),
    .done_set    (done_set),
    .err_set     (err_set),
    .aborted_set (aborted_set),
    .tiles_done  (tiles_done),
    .array_en    (array_en),
    .load_weight (load_weight),
    .tile_row    (tile_row),
    .tile_col    (tile_col),
    .row_mask    (row_mask),
    .col_mask    (col_mask)
  );

endmodule

// File: tb/tb_ml_accel_tile_ctrl_axil.sv
// Directed self-checking bench for ml_accel_tile_ctrl_axil (ARRAY_DIM=16).
module tb_ml_accel_tile_ctrl_axil;

  localparam logic [5:0] A_CTRL = 6'h00, A_STATUS = 6'h04, A_M = 6'h08,
                         A_K = 6'h0C, A_N = 6'h10, A_TILES = 6'h14,
                         A_VERSION = 6'h18, A_BAD = 6'h1C;

  logic        s_axi_aclk = 1'b0;
  logic        s_axi_aresetn = 1'b0;
  logic [5:0]  s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b1;
  logic [5:0]  s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b1;
  logic        array_en, load_weight, irq;
  logic [15:0] tile_row, tile_col, row_mask, col_mask;

  ml_accel_tile_ctrl_axil dut (
    .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .array_en(array_en), .load_weight(load_weight), .tile_row(tile_row), .tile_col(tile_col),
    .row_mask(row_mask), .col_mask(col_mask), .irq(irq)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  int checks = 0;
  int errors = 0;

  // Activity monitor, sampled on the falling edge.
  logic mon_on = 1'b0, started = 1'b0, lw_prev = 1'b0;
  int   en_cnt = 0, lw_cnt = 0, lw_rise = 0, run_cnt = 0;

  always @(negedge s_axi_aclk) begin
    if (mon_on) begin
      if (array_en) en_cnt++;
      if (load_weight) lw_cnt++;
      if (load_weight && !lw_prev) lw_rise++;
      if (array_en) started = 1'b1;
      if (started && !irq) run_cnt++;
    end
    lw_prev = load_weight;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_start();
    mon_on = 1'b0;
    en_cnt = 0; lw_cnt = 0; lw_rise = 0; run_cnt = 0; started = 1'b0;
    #1 mon_on = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge s_axi_aclk);
  endtask

  // post_en is array_en in the cycle right after the write commits.
  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp,
                           output logic post_en);
    int n;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 20) begin @(negedge s_axi_aclk); n++; end
    check("wr_awready", s_axi_awready, 1'b1);
    @(negedge s_axi_aclk);
    post_en = array_en;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin @(negedge s_axi_aclk); n++; end
    check("wr_bvalid", s_axi_bvalid, 1'b1);
    resp = s_axi_bresp;
    @(negedge s_axi_aclk);
  endtask

  task automatic wr(input logic [5:0] addr, input logic [31:0] data);
    logic [1:0] r;
    logic       e;
    axi_write(addr, data, 4'hF, r, e);
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 20) begin @(negedge s_axi_aclk); n++; end
    check("rd_arready", s_axi_arready, 1'b1);
    @(negedge s_axi_aclk);
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin @(negedge s_axi_aclk); n++; end
    check("rd_rvalid", s_axi_rvalid, 1'b1);
    data = s_axi_rdata;
    resp = s_axi_rresp;
    @(negedge s_axi_aclk);
  endtask

  task automatic rd_check(input string tag, input logic [5:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(addr, d, r);
    check(tag, d, exp);
  endtask

  logic [31:0] rdat;
  logic [1:0]  resp;
  logic        post_en, seen;
  int          n;

  initial begin
    // ---- 1: reset values and register readback ----
    cycles(3);
    check("rst_array_en", array_en, 1'b0);
    check("rst_load_weight", load_weight, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_tile_row", tile_row, 16'h0);
    check("rst_awready", s_axi_awready, 1'b0);
    check("rst_bvalid", s_axi_bvalid, 1'b0);
    check("rst_rvalid", s_axi_rvalid, 1'b0);
    check("rst_rdata", s_axi_rdata, 32'h0);
    s_axi_aresetn = 1'b1;
    cycles(2);
    rd_check("t1_ctrl", A_CTRL, 32'h0);
    rd_check("t1_status", A_STATUS, 32'h0);
    rd_check("t1_m", A_M, 32'd16);
    rd_check("t1_k", A_K, 32'd16);
    rd_check("t1_n", A_N, 32'd16);
    rd_check("t1_tiles", A_TILES, 32'd0);
    axi_read(A_VERSION, rdat, resp);
    check("t1_version", rdat, 32'h0002_0000);
    check("t1_version_resp", resp, 2'b00);
    axi_read(A_BAD, rdat, resp);
    check("t1_bad_data", rdat, 32'h0);
    check("t1_bad_resp", resp, 2'b10);

    // ---- 2: M=20 K=8 N=16 -> 2 tiles ----
    wr(A_M, 32'd20);
    wr(A_K, 32'd8);
    wr(A_CTRL, 32'h4);
    mon_start();
    axi_write(A_CTRL, 32'h5, 4'hF, resp, post_en);
    check("t2_en_after_start", post_en, 1'b1);
    check("t2_tile0_row_mask", row_mask, 16'hFFFF);
    check("t2_tile0_load", load_weight, 1'b1);
    n = 0;
    while (tile_row != 16'd1 && n < 300) begin @(negedge s_axi_aclk); n++; end
    check("t2_tile1_row", tile_row, 16'd1);
    check("t2_tile1_col", tile_col, 16'd0);
    check("t2_tile1_row_mask", row_mask, 16'h000F);
    check("t2_tile1_col_mask", col_mask, 16'hFFFF);
    check("t2_tile1_load", load_weight, 1'b1);
    n = 0;
    while (!irq && n < 1000) begin @(negedge s_axi_aclk); n++; end
    check("t2_irq", irq, 1'b1);
    mon_on = 1'b0;
    check("t2_en_cycles", en_cnt, 32'd110);
    check("t2_load_cycles", lw_cnt, 32'd32);
    check("t2_load_phases", lw_rise, 32'd2);
    check("t2_run_cycles", run_cnt, 32'd113);
    rd_check("t2_status", A_STATUS, 32'h2);
    rd_check("t2_tiles", A_TILES, 32'd2);

    // ---- 3: W1C DONE ----
    wr(A_STATUS, 32'h2);
    check("t3_irq_clear", irq, 1'b0);
    rd_check("t3_status", A_STATUS, 32'h0);

    // ---- 4: K=0 -> ERR, no run ----
    wr(A_K, 32'd0);
    mon_start();
    wr(A_CTRL, 32'h5);
    rd_check("t4_status", A_STATUS, 32'h4);
    check("t4_irq", irq, 1'b1);
    cycles(10);
    mon_on = 1'b0;
    check("t4_no_array_en", en_cnt, 32'd0);
    rd_check("t4_tiles_kept", A_TILES, 32'd2);
    wr(A_STATUS, 32'h4);
    check("t4_irq_clear", irq, 1'b0);

    // ---- 5: 4x4 tiles, abort during COMPUTE of tile 2 ----
    wr(A_M, 32'd64);
    wr(A_N, 32'd64);
    wr(A_K, 32'd8);
    wr(A_CTRL, 32'h5);
    n = 0;
    while (!(tile_col == 16'd2 && array_en && !load_weight) && n < 1000) begin
      @(negedge s_axi_aclk); n++;
    end
    check("t5_reach_compute2", tile_col, 16'd2);
    axi_write(A_CTRL, 32'h6, 4'hF, resp, post_en);
    check("t5_en_next_cycle", post_en, 1'b0);
    check("t5_load_weight", load_weight, 1'b0);
    rd_check("t5_status", A_STATUS, 32'h8);
    rd_check("t5_tiles", A_TILES, 32'd2);
    check("t5_irq", irq, 1'b1);
    mon_start();
    cycles(20);
    mon_on = 1'b0;
    check("t5_stays_idle", en_cnt, 32'd0);
    wr(A_STATUS, 32'h8);
    rd_check("t5_status_clr", A_STATUS, 32'h0);

    // ---- 6: back-pressure on B, busy write ignored ----
    s_axi_bready = 1'b0;
    s_axi_awaddr = A_M; s_axi_wdata = 32'h25; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 20) begin @(negedge s_axi_aclk); n++; end
    check("t6_aw1", s_axi_awready, 1'b1);
    @(negedge s_axi_aclk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("t6_b1_valid", s_axi_bvalid, 1'b1);
    s_axi_awaddr = A_K; s_axi_wdata = 32'h5;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(negedge s_axi_aclk); if (s_axi_awready) seen = 1'b1; end
    check("t6_aw_blocked", seen, 1'b0);
    check("t6_b1_held", s_axi_bvalid, 1'b1);
    s_axi_bready = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 20) begin @(negedge s_axi_aclk); n++; end
    check("t6_aw2", s_axi_awready, 1'b1);
    @(negedge s_axi_aclk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin @(negedge s_axi_aclk); n++; end
    check("t6_b2_resp", s_axi_bresp, 2'b00);
    @(negedge s_axi_aclk);
    rd_check("t6_m", A_M, 32'h25);
    rd_check("t6_k", A_K, 32'h5);
    wr(A_CTRL, 32'h5);
    axi_write(A_M, 32'hFF, 4'h1, resp, post_en);
    check("t6_busy_write_resp", resp, 2'b00);
    rd_check("t6_m_unchanged", A_M, 32'h25);
    rd_check("t6_busy_status", A_STATUS, 32'h1);
    wr(A_CTRL, 32'h6);
    wr(A_STATUS, 32'h8);

    // ---- extras: partial strobe, bad write, reset mid-run ----
    axi_write(A_N, 32'h0000_0100, 4'h2, resp, post_en);
    rd_check("strobe_n", A_N, 32'h0140);
    axi_write(A_BAD, 32'hDEAD_BEEF, 4'hF, resp, post_en);
    check("bad_write_resp", resp, 2'b10);
    wr(A_CTRL, 32'h5);
    cycles(5);
    s_axi_aresetn = 1'b0;
    #1;
    check("rst_mid_array_en", array_en, 1'b0);
    check("rst_mid_load_weight", load_weight, 1'b0);
    check("rst_mid_irq", irq, 1'b0);
    @(negedge s_axi_aclk);
    s_axi_aresetn = 1'b1;
    cycles(2);
    rd_check("rst_mid_m", A_M, 32'd16);
    rd_check("rst_mid_status", A_STATUS, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
